// File: rtl/mac_acc_sequencer.sv
`timescale 1ns/1ps
// mac_acc_sequencer: job-level controller that runs one MAC job on mac_acc_block and returns accumulator deltas
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   job_valid/job_ready           job request handshake, job_mode/job_len latched on accept
//   op_valid/op_ready, op_p0..3   operand beat stream, one beat per handshake
//   partial0..3, cfg, mac_en      drive into mac_acc_block
//   acc0..3                       mac_acc_block accumulator outputs
//   res_valid/res_ready, res0..3  job result handshake
//   busy                          high whenever a job is in progress
module mac_acc_sequencer #(
  parameter int INT_WIDTH = 32,
  parameter int ACC_WIDTH = 32,
  parameter int CONF_WIDTH = 3,
  parameter int CNT_WIDTH = 16,
  parameter int SETTLE = 2,
  parameter logic [CONF_WIDTH-2:0] MODE_DUAL = (CONF_WIDTH-1)'(1),
  parameter logic [CONF_WIDTH-2:0] MODE_QUAD = (CONF_WIDTH-1)'(2)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            job_valid,
  output logic                            job_ready,
  input  logic [CONF_WIDTH-2:0]           job_mode,
  input  logic [CNT_WIDTH-1:0]            job_len,
  input  logic                            op_valid,
  output logic                            op_ready,
  input  logic [INT_WIDTH-1:0]            op_p0,
  input  logic [INT_WIDTH-1:0]            op_p1,
  input  logic [INT_WIDTH-1:0]            op_p2,
  input  logic [INT_WIDTH-1:0]            op_p3,
  output logic [INT_WIDTH-1:0]            partial0,
  output logic [INT_WIDTH-1:0]            partial1,
  output logic [INT_WIDTH-1:0]            partial2,
  output logic [INT_WIDTH-1:0]            partial3,
  output logic [4*ACC_WIDTH+CONF_WIDTH-1:0] cfg,
  output logic                            mac_en,
  input  logic [ACC_WIDTH-1:0]            acc0,
  input  logic [ACC_WIDTH-1:0]            acc1,
  input  logic [ACC_WIDTH-1:0]            acc2,
  input  logic [ACC_WIDTH-1:0]            acc3,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [ACC_WIDTH-1:0]            res0,
  output logic [ACC_WIDTH-1:0]            res1,
  output logic [ACC_WIDTH-1:0]            res2,
  output logic [ACC_WIDTH-1:0]            res3,
  output logic                            busy
);
  localparam int SW = $clog2(SETTLE) + 1;
  localparam int W2 = 2 * ACC_WIDTH;
  localparam int W4 = 4 * ACC_WIDTH;
  typedef enum logic [2:0] {S_IDLE, S_LOAD_A, S_LOAD_B, S_RUN, S_SETTLE, S_DONE} state_t;
  state_t state, state_d;
  logic [CNT_WIDTH-1:0] rem;
  logic [SW-1:0] settle_cnt;
  logic [CONF_WIDTH-2:0] mode_q;
  logic acc_sel_q;
  logic [W4-1:0] acc_w, base_q, res_q, diff, diff_single;
  logic [W2-1:0] diff_lo, diff_hi;
  logic beat;
  assign beat = op_valid & op_ready;
  assign acc_w = {acc3, acc2, acc1, acc0};
  // A zero partial is a hold because the block adds on every enabled cycle.
  assign partial0 = beat ? op_p0 : '0;
  assign partial1 = beat ? op_p1 : '0;
  assign partial2 = beat ? op_p2 : '0;
  assign partial3 = beat ? op_p3 : '0;
  // Initial-value field stays zero: results come from snapshots, not from clearing.
  assign cfg = {{W4{1'b0}}, acc_sel_q, mode_q};
  assign {res3, res2, res1, res0} = res_q;
  // Difference at the carry width of the latched mode; modular wrap is harmless.
  genvar k;
  for (k = 0; k < 4; k++) begin : g_lane
    assign diff_single[k*ACC_WIDTH +: ACC_WIDTH] = acc_w[k*ACC_WIDTH +: ACC_WIDTH] - base_q[k*ACC_WIDTH +: ACC_WIDTH];
  end
  assign diff_lo = acc_w[W2-1:0] - base_q[W2-1:0];
  assign diff_hi = acc_w[W4-1:W2] - base_q[W4-1:W2];
  assign diff = mode_q == MODE_QUAD ? acc_w - base_q :
                mode_q == MODE_DUAL ? {diff_hi, diff_lo} : diff_single;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= S_IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:   if (job_valid) state_d = S_LOAD_A;
      S_LOAD_A: state_d = S_LOAD_B;
      S_LOAD_B: state_d = rem == '0 ? S_SETTLE : S_RUN;
      S_RUN:    if (beat && rem == CNT_WIDTH'(1)) state_d = S_SETTLE;
      S_SETTLE: if (settle_cnt == '0) state_d = S_DONE;
      S_DONE:   if (res_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end
  always_comb begin
    job_ready = rst && state == S_IDLE;
    op_ready = state == S_RUN;
    mac_en = state inside {S_LOAD_A, S_LOAD_B, S_RUN, S_SETTLE};
    res_valid = state == S_DONE;
    busy = state != S_IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rem <= '0;
      settle_cnt <= '0;
      mode_q <= '0;
      acc_sel_q <= 1'b0;
      base_q <= '0;
      res_q <= '0;
    end else begin
      if (state == S_IDLE && job_valid) begin
        mode_q <= job_mode;
        rem <= job_len;
        acc_sel_q <= 1'b1;
      end
      if (state == S_LOAD_B) base_q <= acc_w;
      if (beat) rem <= rem - 1'b1;
      if (state_d == S_SETTLE && state != S_SETTLE) settle_cnt <= SW'(SETTLE - 1);
      else if (state == S_SETTLE) settle_cnt <= settle_cnt - 1'b1;
      if (state == S_SETTLE && settle_cnt == '0) res_q <= diff;
    end
endmodule
